psw_reg: RTL and testbench

Processor status word register: the consumer of the ALU flag-update bus (masked value + mask from the flag generator). It holds the architectural PSW, applies masked flag updates, full software writes, and exception-entry push / return pop through a small internal shadow stack. It evaluates the 16 branch/conditional-execution condition codes against the current PSW. It sits beside the register file in the execute stage and feeds the branch unit.

---
 rtl/psw_reg_pkg.sv | 42 ++++
 rtl/psw_reg_cond_eval.sv | 37 +++
 rtl/psw_reg.sv | 110 +++++++++++
 tb/tb_psw_reg.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/psw_reg_pkg.sv
// Shared definitions for the processor status word: bit positions, field ranges,
// reset value and the condition-code encoding used by the branch unit.
package psw_reg_pkg;

  localparam int PSW_W = 16;

  localparam int C_BIT   = 0;
  localparam int Z_BIT   = 1;
  localparam int N_BIT   = 2;
  localparam int SLP_BIT = 3;
  localparam int V_BIT   = 4;

  localparam int CUR_PRIO_LSB  = 5;
  localparam int CUR_PRIO_MSB  = 7;
  localparam int PREV_PRIO_LSB = 13;
  localparam int PREV_PRIO_MSB = 15;

  localparam logic [PSW_W-1:0] PSW_RESET = 16'h00E0;
  // Only the arithmetic flags may be touched by a masked update.
  localparam logic [PSW_W-1:0] FLAG_MASK = 16'h0017;
  localparam logic [PSW_W-1:0] RSVD_MASK = 16'h1F00;

  typedef enum logic [3:0] {
    COND_EQ = 4'd0,
    COND_NE = 4'd1,
    COND_CS = 4'd2,
    COND_CC = 4'd3,
    COND_MI = 4'd4,
    COND_PL = 4'd5,
    COND_VS = 4'd6,
    COND_VC = 4'd7,
    COND_HI = 4'd8,
    COND_LS = 4'd9,
    COND_GE = 4'd10,
    COND_LT = 4'd11,
    COND_GT = 4'd12,
    COND_LE = 4'd13,
    COND_AL = 4'd14,
    COND_NV = 4'd15
  } cond_e;

endpackage

// File: rtl/psw_reg_cond_eval.sv
// Pure combinational condition-code decoder over the four arithmetic flags.
// Takes the flags individually so the branch unit can reuse it with any source.
module psw_cond_eval
  import psw_reg_pkg::*;
(
  input  logic       flag_c,
  input  logic       flag_z,
  input  logic       flag_n,
  input  logic       flag_v,
  input  logic [3:0] cond_code,
  output logic       cond_true
);

  always_comb begin
    cond_true = 1'b0;
    case (cond_e'(cond_code))
      COND_EQ: cond_true = flag_z;
      COND_NE: cond_true = !flag_z;
      COND_CS: cond_true = flag_c;
      COND_CC: cond_true = !flag_c;
      COND_MI: cond_true = flag_n;
      COND_PL: cond_true = !flag_n;
      COND_VS: cond_true = flag_v;
      COND_VC: cond_true = !flag_v;
      COND_HI: cond_true = flag_c && !flag_z;
      COND_LS: cond_true = !flag_c || flag_z;
      COND_GE: cond_true = (flag_n == flag_v);
      COND_LT: cond_true = (flag_n != flag_v);
      COND_GT: cond_true = !flag_z && (flag_n == flag_v);
      COND_LE: cond_true = flag_z || (flag_n != flag_v);
      COND_AL: cond_true = 1'b1;
      COND_NV: cond_true = 1'b0;
      default: cond_true = 1'b0;
    endcase
  end

endmodule

// File: rtl/psw_reg.sv
// Architectural PSW with masked flag updates, full writes, and an internal
// shadow stack for exception entry/return. Condition evaluation is zero-latency.
module psw_reg
  import psw_reg_pkg::*;
#(
  parameter int STACK_DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           upd_en,
  input  logic [15:0]                    upd_val,
  input  logic [15:0]                    upd_msk,
  input  logic                           wr_en,
  input  logic [15:0]                    wr_val,
  input  logic                           push,
  input  logic [2:0]                     push_prio,
  input  logic                           pop,
  input  logic                           clr_err,
  input  logic [3:0]                     cond_code,
  output logic [15:0]                    psw,
  output logic                           cond_true,
  output logic [$clog2(STACK_DEPTH):0]   stk_depth,
  output logic                           stk_full,
  output logic                           stk_empty,
  output logic                           err_ovf,
  output logic                           err_udf
);

  localparam int AW = $clog2(STACK_DEPTH);
  localparam int DW = AW + 1;

  logic [15:0]   psw_q, psw_next;
  logic [DW-1:0] depth_q, depth_next, depth_m1;
  logic          ovf_q, udf_q, ovf_set, udf_set, do_push;
  logic [15:0]   upd_m;
  logic [15:0]   stack_q [STACK_DEPTH];

  assign depth_m1  = depth_q - DW'(1);
  assign stk_full  = (depth_q == DW'(STACK_DEPTH));
  assign stk_empty = (depth_q == '0);
  assign upd_m     = upd_msk & FLAG_MASK;

  // Exception requests outrank software writes, which outrank flag updates.
  always_comb begin
    psw_next   = psw_q;
    depth_next = depth_q;
    ovf_set    = 1'b0;
    udf_set    = 1'b0;
    do_push    = 1'b0;
    if (push && pop) begin
      ovf_set = 1'b1;
      udf_set = 1'b1;
    end else if (push) begin
      if (stk_full) begin
        ovf_set = 1'b1;
      end else begin
        do_push    = 1'b1;
        depth_next = depth_q + DW'(1);
        psw_next   = {psw_q[CUR_PRIO_MSB:CUR_PRIO_LSB], 5'b0, push_prio, 5'b0};
      end
    end else if (pop) begin
      if (stk_empty) begin
        udf_set = 1'b1;
      end else begin
        depth_next = depth_m1;
        psw_next   = stack_q[depth_m1[AW-1:0]];
      end
    end else if (wr_en) begin
      psw_next = wr_val & ~RSVD_MASK;
    end else if (upd_en) begin
      psw_next = (psw_q & ~upd_m) | (upd_val & upd_m);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      psw_q   <= PSW_RESET;
      depth_q <= '0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      psw_q   <= psw_next;
      depth_q <= depth_next;
      ovf_q   <= ovf_set | (ovf_q & ~clr_err);
      udf_q   <= udf_set | (udf_q & ~clr_err);
    end
  end

  // Stack contents are meaningless once depth is reset, so they carry no reset.
  always_ff @(posedge clk) begin
    if (do_push) begin
      stack_q[depth_q[AW-1:0]] <= psw_q;
    end
  end

  psw_cond_eval u_cond (
    .flag_c    (psw_q[C_BIT]),
    .flag_z    (psw_q[Z_BIT]),
    .flag_n    (psw_q[N_BIT]),
    .flag_v    (psw_q[V_BIT]),
    .cond_code (cond_code),
    .cond_true (cond_true)
  );

  assign psw       = psw_q;
  assign stk_depth = depth_q;
  assign err_ovf   = ovf_q;
  assign err_udf   = udf_q;

endmodule

// File: tb/tb_psw_reg.sv
// Directed bench for psw_reg: flag updates, writes, shadow stack, errors,
// condition codes and asynchronous reset, with hand-computed expectations.
module tb_psw_reg;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        upd_en, wr_en, push, pop, clr_err;
  logic [15:0] upd_val, upd_msk, wr_val;
  logic [2:0]  push_prio;
  logic [3:0]  cond_code;
  logic [15:0] psw;
  logic        cond_true, stk_full, stk_empty, err_ovf, err_udf;
  logic [2:0]  stk_depth;

  int n_cmp = 0;
  int n_err = 0;
  logic [15:0] exp_q[$];
  logic [15:0] tmp;

  always #5 clk = ~clk;

  psw_reg #(.STACK_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .upd_en(upd_en), .upd_val(upd_val),
    .upd_msk(upd_msk), .wr_en(wr_en), .wr_val(wr_val), .push(push),
    .push_prio(push_prio), .pop(pop), .clr_err(clr_err),
    .cond_code(cond_code), .psw(psw), .cond_true(cond_true),
    .stk_depth(stk_depth), .stk_full(stk_full), .stk_empty(stk_empty),
    .err_ovf(err_ovf), .err_udf(err_udf)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    upd_en = 0; wr_en = 0; push = 0; pop = 0; clr_err = 0;
    upd_val = '0; upd_msk = '0; wr_val = '0; push_prio = '0;
  endtask

  // Apply the currently driven request on one edge, then sample 1 ns later.
  task automatic tick();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic do_wr(input logic [15:0] v);
    wr_en = 1; wr_val = v; tick();
  endtask

  task automatic do_upd(input logic [15:0] v, input logic [15:0] m);
    upd_en = 1; upd_val = v; upd_msk = m; tick();
  endtask

  task automatic do_push(input logic [2:0] p);
    push = 1; push_prio = p; tick();
  endtask

  task automatic check_conds(input string tag, input logic [15:0] exp_vec);
    for (int i = 0; i < 16; i++) begin
      cond_code = 4'(i);
      #1;
      check($sformatf("%s_cc%0d", tag, i), 32'(cond_true), 32'(exp_vec[i]));
    end
  endtask

  initial begin
    idle();
    cond_code = 4'd0;
    rst_n = 0;
    #12;
    check("rst_psw", 32'(psw), 32'h00E0);
    check("rst_empty", 32'(stk_empty), 1);
    check("rst_full", 32'(stk_full), 0);
    check("rst_depth", 32'(stk_depth), 0);
    check("rst_errs", {30'b0, err_ovf, err_udf}, 0);
    rst_n = 1;
    @(posedge clk); #1;

    do_upd(16'h0017, 16'h0017);
    check("upd_all_flags", 32'(psw), 32'h00F7);
    check_conds("condC", 16'h6655);

    do_wr(16'h00E0);
    check("wr_e0", 32'(psw), 32'h00E0);
    check_conds("condA", 16'h56AA);
    do_upd(16'hFFFF, 16'h0001);
    check("upd_c_only", 32'(psw), 32'h00E1);
    do_upd(16'hFFFF, 16'h0008);
    check("upd_slp_ignored", 32'(psw), 32'h00E1);
    do_upd(16'h0000, 16'hFFE8);
    check("upd_nonflag_ignored", 32'(psw), 32'h00E1);

    wr_en = 1; wr_val = 16'hFFFF; upd_en = 1; upd_val = 16'h0000; upd_msk = 16'hFFFF;
    tick();
    check("wr_beats_upd", 32'(psw), 32'hE0FF);

    do_wr(16'h00E5);
    check_conds("condB", 16'h6996);
    cond_code = 4'd2;
    upd_en = 1; upd_val = 16'h0000; upd_msk = 16'h0001;
    #1;
    check("cond_pre_update", 32'(cond_true), 1);
    tick();
    check("upd_clear_c", 32'(psw), 32'h00E4);
    check("cond_post_update", 32'(cond_true), 0);
    do_wr(16'h00E5);

    // Pushes: save the pre-push PSW as the expected pop result.
    exp_q.push_back(psw);
    do_push(3'd2);
    check("push1_psw", 32'(psw), 32'hE040);
    exp_q.push_back(psw);
    do_push(3'd3);
    check("push2_psw", 32'(psw), 32'h4060);
    exp_q.push_back(psw);
    do_push(3'd5);
    check("push3_psw", 32'(psw), 32'h60A0);
    exp_q.push_back(psw);
    do_push(3'd6);
    check("push4_psw", 32'(psw), 32'hA0C0);
    check("push4_depth", 32'(stk_depth), 4);
    check("push4_full", 32'(stk_full), 1);
    push = 1; push_prio = 3'd1; clr_err = 1; wr_en = 1; wr_val = 16'h1234;
    tick();
    check("ovf_psw", 32'(psw), 32'hA0C0);
    check("ovf_flag", 32'(err_ovf), 1);
    check("ovf_depth", 32'(stk_depth), 4);
    check("ovf_no_udf", 32'(err_udf), 0);

    for (int i = 0; i < 4; i++) begin
      pop = 1; tick();
      tmp = exp_q.pop_back();
      check($sformatf("pop%0d_psw", i + 1), 32'(psw), 32'(tmp));
      check($sformatf("pop%0d_depth", i + 1), 32'(stk_depth), 32'(3 - i));
    end
    check("pop_restore", 32'(psw), 32'h00E5);
    check("pop_empty", 32'(stk_empty), 1);
    pop = 1; tick();
    check("udf_flag", 32'(err_udf), 1);
    check("udf_psw", 32'(psw), 32'h00E5);
    check("udf_depth", 32'(stk_depth), 0);

    clr_err = 1; tick();
    check("clr_errs", {30'b0, err_ovf, err_udf}, 0);

    do_push(3'd1);
    check("pp_setup_psw", 32'(psw), 32'hE020);
    push = 1; pop = 1; wr_en = 1; wr_val = 16'h0001; push_prio = 3'd4;
    tick();
    check("pp_depth", 32'(stk_depth), 1);
    check("pp_psw", 32'(psw), 32'hE020);
    check("pp_errs", {30'b0, err_ovf, err_udf}, 3);
    clr_err = 1; tick();
    check("pp_clr", {30'b0, err_ovf, err_udf}, 0);

    do_push(3'd3);
    do_push(3'd4);
    check("pre_rst_depth", 32'(stk_depth), 3);
    #2;
    rst_n = 0;
    #1;
    check("async_psw", 32'(psw), 32'h00E0);
    check("async_depth", 32'(stk_depth), 0);
    check("async_empty", 32'(stk_empty), 1);
    #3;
    rst_n = 1;
    @(posedge clk); #1;
    pop = 1; tick();
    check("post_rst_udf", 32'(err_udf), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
